// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: synchronizes and debounces the rows, walks the columns to locate a single
// pressed key, and queues one 4-bit code per press in a small valid/ready FIFO.
module keypad_scan_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SCAN_DWELL      = 4,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] Row,
   input  logic       scan_en,
   output logic [3:0] Col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [4:0] fifo_count,
   output logic       overflow,
   input  logic       clear_ovf,
   output logic       ghost
);

   localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [7:0]  DebLast   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]  DwellLast = 8'(SCAN_DWELL - 1);
   localparam logic [4:0]  Depth     = 5'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StDebPress, StScan, StPush, StWaitRel} state_e;

   state_e     state_q;
   logic [3:0] row_meta_q, row_s_q;
   logic [7:0] cnt_q, dwell_q;
   logic [1:0] col_idx_q;
   logic [3:0] code_q;
   logic       ghost_q;

   logic       row_any, row_one;
   logic [1:0] row_idx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row_meta_q <= 4'h0;
         row_s_q    <= 4'h0;
      end else begin
         row_meta_q <= Row;
         row_s_q    <= row_meta_q;
      end
   end

   assign row_any = |row_s_q;
   // Power-of-two test: a single set bit clears to zero when ANDed with itself minus one.
   assign row_one = row_any && ((row_s_q & (row_s_q - 4'd1)) == 4'h0);

   always_comb begin
      row_idx = 2'd0;
      case (row_s_q)
         4'b0010: row_idx = 2'd1;
         4'b0100: row_idx = 2'd2;
         4'b1000: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         dwell_q   <= 8'd0;
         col_idx_q <= 2'd0;
         code_q    <= 4'h0;
         ghost_q   <= 1'b0;
      end else begin
         ghost_q <= 1'b0;
         if (!scan_en) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            dwell_q   <= 8'd0;
            col_idx_q <= 2'd0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  cnt_q <= 8'd0;
                  if (row_any) state_q <= StDebPress;
               end
               StDebPress: begin
                  if (!row_any) begin
                     state_q <= StIdle;
                     cnt_q   <= 8'd0;
                  end else if (cnt_q == DebLast) begin
                     state_q   <= StScan;
                     cnt_q     <= 8'd0;
                     col_idx_q <= 2'd0;
                     dwell_q   <= 8'd0;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               StScan: begin
                  if (dwell_q != DwellLast) begin
                     dwell_q <= dwell_q + 8'd1;
                  end else begin
                     dwell_q <= 8'd0;
                     if (row_one) begin
                        code_q  <= {row_idx, col_idx_q};
                        state_q <= StPush;
                     end else if (row_any) begin
                        ghost_q <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= StWaitRel;
                     end else if (col_idx_q != 2'd3) begin
                        col_idx_q <= col_idx_q + 2'd1;
                     end else begin
                        state_q <= StIdle;
                     end
                  end
               end
               StPush: begin
                  cnt_q   <= 8'd0;
                  state_q <= StWaitRel;
               end
               StWaitRel: begin
                  if (row_any) begin
                     cnt_q <= 8'd0;
                  end else if (cnt_q == DebLast) begin
                     cnt_q   <= 8'd0;
                     state_q <= StIdle;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   always_comb begin
      Col = 4'h0;
      if (scan_en) Col = (state_q == StScan) ? (4'b0001 << col_idx_q) : 4'b1111;
   end

   assign ghost = ghost_q;

   // Key-code FIFO
   logic [3:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [4:0]      count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            push_req, push, pop, full;

   assign full     = (count_q == Depth);
   assign push_req = (state_q == StPush) && scan_en;
   assign pop      = key_valid && key_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the code.
   assign push     = push_req && (!full || pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (push_req && full && !pop) ovf_d = 1'b1;
      else if (clear_ovf)           ovf_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= code_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign key_valid  = (count_q != 5'd0);
   assign key_code   = key_valid ? mem_q[rd_ptr_q] : 4'h0;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench: keypad matrix model drives Row from Col; expected codes go into a queue that a
// negedge monitor pops on every accepted handshake.
module tb_keypad_scan_controller;

   localparam int Deb   = 16;
   localparam int Dwell = 4;
   localparam int Depth = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  Row;
   logic        scan_en = 1'b1;
   logic [3:0]  Col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ready = 1'b0;
   logic [4:0]  fifo_count;
   logic        overflow;
   logic        clear_ovf = 1'b0;
   logic        ghost;
   logic [15:0] keys = 16'h0;

   int          n_cmp = 0;
   int          n_err = 0;
   int          ghost_cnt = 0;
   logic [3:0]  exp_q[$];
   logic        m_ovf = 1'b0;

   keypad_scan_controller #(
      .DEBOUNCE_CYCLES(Deb),
      .SCAN_DWELL     (Dwell),
      .FIFO_DEPTH     (Depth)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .Row       (Row),
      .scan_en   (scan_en),
      .Col       (Col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .fifo_count(fifo_count),
      .overflow  (overflow),
      .clear_ovf (clear_ovf),
      .ghost     (ghost)
   );

   always #5 clock = ~clock;

   // Key (r,c) shorts column c onto row r.
   always_comb begin
      Row = 4'h0;
      for (int r = 0; r < 4; r++) Row[r] = |(keys[4*r +: 4] & Col);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n, input bit rr);
      repeat (n) begin
         @(posedge clock);
         #1;
         if (rr) key_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic expect_code(input int code, input bit pop_same);
      if (exp_q.size() < Depth || pop_same) exp_q.push_back(4'(code));
      else m_ovf = 1'b1;
   endtask

   // Press a key for 'hold' cycles then release through the release debounce. With pop_same,
   // key_ready is raised for exactly the cycle in which the code is written.
   task automatic press(input int code, input int hold, input bit rr, input bit pop_same);
      int wr;
      wr = 2 + Deb + Dwell * ((code % 4) + 1) + 2;
      expect_code(code, pop_same);
      keys = 16'(1) << code;
      for (int i = 1; i <= hold; i++) begin
         @(posedge clock);
         #1;
         if (rr) key_ready = 1'($urandom_range(0, 1));
         if (pop_same) key_ready = (i == wr - 1);
      end
      keys = 16'h0;
      step(Deb + 8, rr);
   endtask

   initial begin
      int         lat;
      logic [3:0] lat_code;
      int         g0;

      fork
         forever begin
            @(negedge clock);
            if (reset) begin
               if (ghost) ghost_cnt++;
               if (key_valid && key_ready) begin
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL pop: unexpected code %0h, expected none", key_code);
                  end else begin
                     check("pop_code", int'(key_code), int'(exp_q.pop_front()));
                  end
               end
            end
         end
      join_none

      // Reset state
      #12;
      check("rst_valid", int'(key_valid), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_ghost", int'(ghost), 0);
      check("rst_code", int'(key_code), 0);
      check("rst_col", int'(Col), 4'hf);
      @(negedge clock);
      reset = 1'b1;
      step(2, 0);
      scan_en = 1'b0;
      #1;
      check("halt_col", int'(Col), 0);
      scan_en = 1'b1;
      #1;
      check("run_col", int'(Col), 4'hf);
      step(2, 0);

      // Single press row2/col1: latency and exactly one code while held
      expect_code(9, 0);
      keys = 16'(1) << 9;
      lat = -1;
      lat_code = 4'h0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clock);
         #1;
         if (key_valid && lat < 0) begin
            lat = i;
            lat_code = key_code;
         end
      end
      check("latency", lat, 2 + Deb + Dwell * 2 + 2);
      check("latency_code", int'(lat_code), 9);
      keys = 16'h0;
      step(Deb + 8, 0);
      check("single_push", int'(fifo_count), 1);
      key_ready = 1'b1;
      step(3, 0);
      key_ready = 1'b0;
      check("drain1", exp_q.size(), 0);

      // Short glitch is rejected
      keys = 16'h0001;
      step(5, 0);
      keys = 16'h0;
      step(30, 0);
      check("glitch_count", int'(fifo_count), 0);
      check("glitch_col", int'(Col), 4'hf);

      // Two keys in column 3: ghost, no code
      g0 = ghost_cnt;
      keys = (16'(1) << 3) | (16'(1) << 15);
      step(80, 0);
      keys = 16'h0;
      step(Deb + 8, 0);
      check("ghost_pulses", ghost_cnt - g0, 1);
      check("ghost_count", int'(fifo_count), 0);
      check("ghost_col", int'(Col), 4'hf);

      // Overflow with consumer stalled
      press(0, 60, 0, 0);
      press(5, 60, 0, 0);
      press(10, 60, 0, 0);
      press(15, 60, 0, 0);
      press(3, 60, 0, 0);
      check("ovf_count", int'(fifo_count), exp_q.size());
      check("ovf_flag", int'(overflow), int'(m_ovf));
      check("ovf_head", int'(key_code), 0);
      check("ovf_valid", int'(key_valid), 1);
      key_ready = 1'b1;
      step(6, 0);
      key_ready = 1'b0;
      check("ovf_drain", exp_q.size(), 0);
      check("ovf_drain_count", int'(fifo_count), 0);
      clear_ovf = 1'b1;
      m_ovf = 1'b0;
      step(1, 0);
      clear_ovf = 1'b0;
      check("ovf_clear", int'(overflow), int'(m_ovf));

      // Full FIFO with a pop in the push cycle
      press(1, 60, 0, 0);
      press(2, 60, 0, 0);
      press(7, 60, 0, 0);
      press(8, 60, 0, 0);
      press(13, 60, 0, 1);
      check("fullpop_count", int'(fifo_count), 4);
      check("fullpop_ovf", int'(overflow), int'(m_ovf));
      key_ready = 1'b1;
      step(6, 0);
      key_ready = 1'b0;
      check("fullpop_drain", exp_q.size(), 0);

      // Reset while scanning column 2 with two codes queued
      press(4, 60, 0, 0);
      press(11, 60, 0, 0);
      keys = 16'(1) << 6;
      step(2 + Deb + 2 * Dwell + 2, 0);
      check("scan_col2", int'(Col), 4'b0100);
      #2;
      reset = 1'b0;
      #1;
      check("mrst_valid", int'(key_valid), 0);
      check("mrst_count", int'(fifo_count), 0);
      check("mrst_col", int'(Col), 4'hf);
      exp_q.delete();
      m_ovf = 1'b0;
      step(3, 0);
      reset = 1'b1;
      expect_code(6, 0);
      lat = -1;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clock);
         #1;
         if (key_valid && lat < 0) lat = i;
      end
      check("rescan_latency", lat, 2 + Deb + Dwell * 3 + 2);
      keys = 16'h0;
      step(Deb + 8, 0);
      key_ready = 1'b1;
      step(3, 0);
      key_ready = 1'b0;
      check("rescan_drain", exp_q.size(), 0);

      // Randomized presses with bounces and a random consumer
      for (int it = 0; it < 16; it++) begin
         int code;
         code = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) begin
            keys = 16'(1) << $urandom_range(0, 15);
            step($urandom_range(1, 8), 1);
            keys = 16'h0;
            step(4, 1);
         end
         press(code, $urandom_range(40, 90), 1, 0);
      end
      key_ready = 1'b1;
      step(10, 0);
      check("final_queue", exp_q.size(), 0);
      check("final_count", int'(fifo_count), 0);
      check("final_ovf", int'(overflow), int'(m_ovf));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
